intc: RTL and testbench
=======================

# intc

Parametrised interrupt controller between the external interrupt lines and the `INT` input of the `mips` core. It is a memory-mapped slave on the same single-cycle `we`/`a`/`d`/`q` data-memory port style as `dmem`. It replaces the raw, hard-wired 5-bit `INT` bus with the following:
- a configurable channel count;
- optional input synchronisation;
- per-channel edge/level mode;
- pending latching, masking and fixed-priority ID encoding.

## Interface
Parameters:
- `N_IRQ`, 5, number of interrupt channels (1..32)
- `AW`, 3, word-address width of register port
- `IDW`, `$clog2(N_IRQ)` (min 1), width of `irq_id`

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `irq_in`  in  N_IRQ  raw interrupt lines, active-high
- `we`  in  1  register write strobe
- `a`  in  AW  word address (CPU byte address bits [AW+1:2])
- `d`  in  32  write data
- `q`  out  32  read data, combinational from `a`
- `int_out`  out  N_IRQ  masked pending vector, drives core `INT`
- `irq`  out  1  OR of `int_out`
- `irq_id`  out  IDW  index of highest-priority active channel

## Operation
Register map (word address; bits above N_IRQ-1 read 0, ignore writes):
- 0 RAW, RO: conditioned input level `s`
- 1 PEND, RW1C: pending vector; write 1 clears edge-mode bits
- 2 MASK, RW: 1 = channel enabled
- 3 MODE, RW: 1 = edge (latched), 0 = level
- 4 ID, RO: bit31 = `irq`, bits[IDW-1:0] = `irq_id`
- 5 SWSET, WO: write 1 sets pending in edge-mode channels; reads 0
- 6..2^AW-1: read 0, writes ignored

Per channel:
- `prev <= s`
- `edge = s & ~prev`
- Edge mode: `pend <= (pend & ~clr) | edge | swset`. Set wins over a same-cycle W1C.
- Level mode: PEND bit reads `s`. The latch is held at 0; W1C and SWSET have no effect.
- A MODE write that changes edge→level clears that channel's latch. Level→edge starts with the latch at 0; a line already high does not produce an edge until it falls and rises again.

Outputs:
- `int_out = PEND & MASK`
- `irq = |int_out`
- `irq_id` = lowest set index of `int_out` (channel 0 highest priority); 0 when `irq`=0.

Reset values:
- PEND, `prev`, sync flops: 0
- MASK: 0
- MODE: all 1 (edge)
- Outputs: `int_out`=0, `irq`=0, `irq_id`=0; `q` follows `a` (PEND/MASK reads 0).

A line held high across reset release is seen as one edge: `prev` resets to 0. Reset mid-operation discards all pending state immediately.

## Timing
- Register write takes effect on the clock edge where `we`=1. Readback and output changes are visible the following cycle.
- Reads are combinational; same-cycle read of a register being written returns the old value.
- `irq_in` rising, first sampled at edge k:
  - with sync: `s` high after k+1; PEND/`int_out` set after k+2
  - without sync: `s` = `irq_in`; PEND set after edge k
- W1C at edge k: `int_out` drops after k unless a new edge arrives on the same cycle.
- Pulses shorter than one clock may be missed; pulses of one clock or more are captured exactly once.

## Configuration
- `INTC_SYNC_EN` defined: two-flop synchroniser per channel ahead of edge detection. Latency as above.
- `INTC_SYNC_EN` undefined: `s` = `irq_in` directly, and only the `prev` flop remains. Use this when all sources are already on `clk`.

## Structure
- `intc_pkg`:
  - register address constants `INTC_RAW`, `INTC_PEND`, `INTC_MASK`, `INTC_MODE`, `INTC_ID`, `INTC_SWSET`
  - ID register bit position `INTC_ID_IRQ_BIT` = 31
  - MODE reset constant
- Sub-module `intc_sync`: one channel's optional synchroniser plus `prev` flop and `edge` output, instantiated N_IRQ times via generate. Register file, priority encoder and read mux stay in `intc`.

## Test plan
- Reset then read regs 0–5 → MODE = 2^N_IRQ−1; all others 0; `irq`=0.
- MASK=0x1F, pulse `irq_in[3]` one cycle → PEND=0x08, `int_out`=0x08, `irq_id`=3 after 3 cycles (sync) or 1 (no sync); write PEND=0x08 → PEND=0, `irq`=0.
- `irq_in[1]` and `[4]` rise together, MASK=0x1F → `irq_id`=1; W1C bit 1 → `irq_id`=4; ID reads 0x8000_0004.
- MODE=0x1E (ch0 level), MASK=0x01, hold `irq_in[0]` high → `int_out[0]`=1 and W1C has no effect; drop the line → PEND[0]=0 after the sync latency.
- Hold W1C on bit 2 in the same cycle a new edge lands on ch2 → PEND[2] stays 1; SWSET=0x04 with MASK=0 → PEND=0x04, `int_out`=0.
- Assert `rst` while PEND=0x1F → next cycle all outputs 0; a line held high through reset release → one pending edge.

Source files
------------

// File: rtl/intc_pkg.sv
// intc_pkg: register map and reset constants shared by the interrupt controller.
package intc_pkg;
    localparam logic [31:0] INTC_RAW   = 32'd0;
    localparam logic [31:0] INTC_PEND  = 32'd1;
    localparam logic [31:0] INTC_MASK  = 32'd2;
    localparam logic [31:0] INTC_MODE  = 32'd3;
    localparam logic [31:0] INTC_ID    = 32'd4;
    localparam logic [31:0] INTC_SWSET = 32'd5;
    localparam int INTC_ID_IRQ_BIT = 31;
    localparam logic [31:0] INTC_MODE_RST = 32'hFFFF_FFFF;
endpackage

// File: rtl/intc_sync.sv
// intc_sync: one channel's conditioned level s and rising-edge pulse.
// INTC_SYNC_EN adds a two-flop synchroniser ahead of edge detection.
module intc_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic s,
    output logic rise
);
    logic prev;
`ifdef INTC_SYNC_EN
    logic meta;
    always_ff @(posedge clk)
        if (rst) {meta, s} <= 2'b00;
        else {meta, s} <= {line, meta};
`else
    assign s = line;
`endif
    // prev resets to 0 so a line held high through reset is seen as one edge
    always_ff @(posedge clk)
        if (rst) prev <= 1'b0;
        else prev <= s;
    assign rise = s & ~prev;
endmodule

// File: rtl/intc.sv
// intc: interrupt controller with pending/mask/mode registers and fixed-priority ID.
// Define INTC_SYNC_EN to synchronise irq_in inside intc_sync.
module intc
    import intc_pkg::*;
#(
    parameter int N_IRQ = 5,
    parameter int AW    = 3,
    parameter int IDW   = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             we,
    input  logic [AW-1:0]    a,
    input  logic [31:0]      d,
    output logic [31:0]      q,
    output logic [N_IRQ-1:0] int_out,
    output logic             irq,
    output logic [IDW-1:0]   irq_id
);
    logic [N_IRQ-1:0] s, rise, latch, latch_n, mask, mode, mode_n, pend, clr, swset, wd;
    logic sel_pend, sel_mask, sel_mode, sel_swset, unused_d;
    genvar i;
    generate
        for (i = 0; i < N_IRQ; i++) begin : g_ch
            intc_sync u_sync (
                .clk (clk),
                .rst (rst),
                .line(irq_in[i]),
                .s   (s[i]),
                .rise(rise[i])
            );
        end
    endgenerate
    assign wd        = d[N_IRQ-1:0];
    assign unused_d  = ^d;
    assign sel_pend  = we && 32'(a) == INTC_PEND;
    assign sel_mask  = we && 32'(a) == INTC_MASK;
    assign sel_mode  = we && 32'(a) == INTC_MODE;
    assign sel_swset = we && 32'(a) == INTC_SWSET;
    assign clr       = sel_pend ? wd : '0;
    assign swset     = sel_swset ? wd : '0;
    assign mode_n    = sel_mode ? wd : mode;
    // Gating with the next mode holds level-mode latches at 0 and clears on edge->level
    assign latch_n   = mode_n & ((latch & ~clr) | rise | swset);
    assign pend      = latch | (~mode & s);
    assign int_out   = pend & mask;
    assign irq       = |int_out;
    always_ff @(posedge clk)
        if (rst) begin
            latch <= '0;
            mask  <= '0;
            mode  <= INTC_MODE_RST[N_IRQ-1:0];
        end else begin
            latch <= latch_n;
            mode  <= mode_n;
            if (sel_mask) mask <= wd;
        end
    always_comb begin
        irq_id = '0;
        for (int j = N_IRQ - 1; j >= 0; j--)
            if (int_out[j]) irq_id = IDW'(j);
    end
    always_comb begin
        q = '0;
        case (32'(a))
            INTC_RAW:  q[N_IRQ-1:0] = s;
            INTC_PEND: q[N_IRQ-1:0] = pend;
            INTC_MASK: q[N_IRQ-1:0] = mask;
            INTC_MODE: q[N_IRQ-1:0] = mode;
            INTC_ID: begin
                q[IDW-1:0] = irq_id;
                q[INTC_ID_IRQ_BIT] = irq;
            end
            default: q = '0;
        endcase
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed and randomized checks of intc against a behavioural model.
module tb_intc;
    localparam int N = 5;
`ifdef INTC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1, we = 1'b0;
    logic [2:0] a = '0;
    logic [31:0] d = '0, q;
    logic [N-1:0] irq_in = '0, int_out;
    logic irq;
    logic [2:0] irq_id;
    int total = 0, bad = 0;
    intc #(.N_IRQ(N)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .we(we), .a(a), .d(d),
        .q(q), .int_out(int_out), .irq(irq), .irq_id(irq_id)
    );
    always #10 clk = ~clk;
    // Model: channel state as seen by software, input history for synchroniser delay
    logic [N-1:0] m_latch, m_mask, m_mode, m_prev;
    logic [N-1:0] hist[$];
    function automatic logic [N-1:0] model_s();
        if (LAT == 0) return irq_in;
        return hist[hist.size() - LAT];
    endfunction
    function automatic logic [N-1:0] exp_pend();
        logic [N-1:0] s = model_s();
        logic [N-1:0] p;
        for (int c = 0; c < N; c++) p[c] = m_mode[c] ? m_latch[c] : s[c];
        return p;
    endfunction
    function automatic logic [N-1:0] exp_int();
        return exp_pend() & m_mask;
    endfunction
    function automatic int exp_id();
        logic [N-1:0] v = exp_int();
        for (int c = 0; c < N; c++) if (v[c]) return c;
        return 0;
    endfunction
    function automatic logic [31:0] exp_q(input int r);
        logic [31:0] v = '0;
        case (r)
            0: v = 32'(model_s());
            1: v = 32'(exp_pend());
            2: v = 32'(m_mask);
            3: v = 32'(m_mode);
            4: begin v = 32'(exp_id()); v[31] = |exp_int(); end
            default: v = '0;
        endcase
        return v;
    endfunction
    task automatic model_reset();
        m_latch = '0; m_mask = '0; m_mode = '1; m_prev = '0;
        hist.delete();
        for (int k = 0; k < LAT; k++) hist.push_back('0);
    endtask
    task automatic model_step();
        logic [N-1:0] s = model_s();
        for (int c = 0; c < N; c++) begin
            logic new_mode = (we && a == 3) ? d[c] : m_mode[c];
            if (!new_mode) m_latch[c] = 1'b0;
            else if ((s[c] && !m_prev[c]) || (we && a == 5 && d[c])) m_latch[c] = 1'b1;
            else if (we && a == 1 && d[c]) m_latch[c] = 1'b0;
            if (we && a == 2) m_mask[c] = d[c];
            m_mode[c] = new_mode;
            m_prev[c] = s[c];
        end
        hist.push_back(irq_in);
    endtask
    task automatic tick();
        if (rst) model_reset(); else model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [2:0] ad, input logic [31:0] da);
        we = 1'b1; a = ad; d = da;
        tick();
        we = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            logic [31:0] e = (r == 3) ? 32'h1F : 32'h0;
            a = 3'(r); #1;
            if (q !== e) begin bad++; $display("FAIL reset_reg%0d got=%h exp=%h", r, q, e); end
            total++;
        end
        if (int_out !== '0) begin bad++; $display("FAIL reset_int_out got=%h exp=0", int_out); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++;
        if (irq_id !== '0) begin bad++; $display("FAIL reset_irq_id got=%0d exp=0", irq_id); end
        total++;
    endtask
    task automatic test_pulse();
        wr(2, 32'h1F);
        irq_in = 5'h08; tick();
        irq_in = '0;
        repeat (LAT) tick();
        a = 1; #1;
        if (q !== 32'h08) begin bad++; $display("FAIL pulse_pend got=%h exp=08", q); end
        total++;
        if (int_out !== 5'h08) begin bad++; $display("FAIL pulse_int_out got=%h exp=08", int_out); end
        total++;
        if (irq_id !== 3'd3) begin bad++; $display("FAIL pulse_irq_id got=%0d exp=3", irq_id); end
        total++;
        wr(1, 32'h08);
        a = 1; #1;
        if (q !== 32'h0) begin bad++; $display("FAIL pulse_w1c got=%h exp=0", q); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL pulse_irq_clr got=%b exp=0", irq); end
        total++;
    endtask
    task automatic test_priority();
        irq_in = 5'h12; tick();
        repeat (LAT) tick();
        if (irq_id !== 3'd1) begin bad++; $display("FAIL prio_id1 got=%0d exp=1", irq_id); end
        total++;
        wr(1, 32'h02);
        if (irq_id !== 3'd4) begin bad++; $display("FAIL prio_id4 got=%0d exp=4", irq_id); end
        total++;
        a = 4; #1;
        if (q !== 32'h8000_0004) begin bad++; $display("FAIL prio_idreg got=%h exp=80000004", q); end
        total++;
        wr(1, 32'h10);
        irq_in = '0;
        repeat (LAT) tick();
        if (irq !== 1'b0) begin bad++; $display("FAIL prio_clear got=%b exp=0", irq); end
        total++;
    endtask
    task automatic test_level();
        wr(3, 32'h1E);
        wr(2, 32'h01);
        irq_in = 5'h01; tick();
        repeat (LAT) tick();
        if (int_out !== 5'h01) begin bad++; $display("FAIL level_high got=%h exp=01", int_out); end
        total++;
        wr(1, 32'h01);
        a = 1; #1;
        if (q !== 32'h01) begin bad++; $display("FAIL level_w1c got=%h exp=01", q); end
        total++;
        irq_in = '0;
        repeat (LAT) tick();
        a = 1; #1;
        if (q !== 32'h0) begin bad++; $display("FAIL level_drop got=%h exp=0", q); end
        total++;
        wr(3, 32'h1F);
        wr(2, 32'h1F);
    endtask
    task automatic test_set_wins();
        irq_in = 5'h04;
        repeat (LAT) tick();
        wr(1, 32'h04);
        a = 1; #1;
        if (q !== 32'h04) begin bad++; $display("FAIL setwins_pend got=%h exp=04", q); end
        total++;
        irq_in = '0;
        wr(1, 32'h04);
        repeat (LAT) tick();
        a = 1; #1;
        if (q !== 32'h0) begin bad++; $display("FAIL setwins_clear got=%h exp=0", q); end
        total++;
        wr(2, 32'h0);
        wr(5, 32'h04);
        a = 1; #1;
        if (q !== 32'h04) begin bad++; $display("FAIL swset_pend got=%h exp=04", q); end
        total++;
        if (int_out !== '0) begin bad++; $display("FAIL swset_masked got=%h exp=0", int_out); end
        total++;
        a = 5; #1;
        if (q !== 32'h0) begin bad++; $display("FAIL swset_read got=%h exp=0", q); end
        total++;
        wr(1, 32'h04);
    endtask
    task automatic test_reset_mid();
        wr(5, 32'h1F);
        wr(2, 32'h1F);
        if (int_out !== 5'h1F) begin bad++; $display("FAIL rstmid_pre got=%h exp=1f", int_out); end
        total++;
        rst = 1'b1; tick();
        if (int_out !== '0 || irq !== 1'b0 || irq_id !== '0) begin
            bad++; $display("FAIL rstmid_outs got=%h/%b/%0d exp=0/0/0", int_out, irq, irq_id);
        end
        total++;
        irq_in = 5'h02; tick();
        rst = 1'b0;
        repeat (1 + LAT) tick();
        a = 1; #1;
        if (q !== 32'h02) begin bad++; $display("FAIL rstmid_edge got=%h exp=02", q); end
        total++;
        repeat (3) tick();
        wr(1, 32'h02);
        a = 1; #1;
        if (q !== 32'h0) begin bad++; $display("FAIL rstmid_once got=%h exp=0", q); end
        total++;
        irq_in = '0;
    endtask
    task automatic test_random();
        rst = 1'b1; tick();
        rst = 1'b0;
        for (int n = 0; n < 400; n++) begin
            irq_in = irq_in ^ N'($urandom & $urandom);
            we = ($urandom_range(0, 2) == 0);
            a = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 3) == 0 && a == 3) ? 32'h1F ^ (32'h1 << $urandom_range(0, 4)) : $urandom;
            tick();
            we = 1'b0;
            if (int_out !== exp_int()) begin bad++; $display("FAIL rnd_int_out cyc=%0d got=%h exp=%h", n, int_out, exp_int()); end
            total++;
            if (irq !== |exp_int()) begin bad++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", n, irq, |exp_int()); end
            total++;
            if (32'(irq_id) !== exp_id()) begin bad++; $display("FAIL rnd_irq_id cyc=%0d got=%0d exp=%0d", n, irq_id, exp_id()); end
            total++;
            a = 3'($urandom_range(0, 7)); #1;
            if (q !== exp_q(int'(a))) begin bad++; $display("FAIL rnd_q cyc=%0d a=%0d got=%h exp=%h", n, a, q, exp_q(int'(a))); end
            total++;
        end
    endtask
    initial begin
        test_reset();
        test_pulse();
        test_priority();
        test_level();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
